// File: rtl/utils_pkg.sv
// utils_pkg: shared PE latencies and width-generic saturation helper
package utils_pkg;
    localparam int PE_UP2DN_LAT = 3;
    localparam int PE_LF2RT_LAT = 1;
    function automatic logic signed [63:0] pe_sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction
endpackage

// File: rtl/pe_wgt_bank.sv
// pe_wgt_bank: stationary weight register file with wrapping write/read pointers and full flag
module pe_wgt_bank #(
    parameter int DEPTH = 4,
    parameter int W = 8,
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full
);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
                if (wr_ptr == LAST) full <= 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/pe_mw.sv
// pe_mw: multi-weight signed saturating MAC PE, down = left * wgt[pop_ptr] + up over 3 stages
// Activations and the load bus are forwarded with one register of delay.
module pe_mw
    import utils_pkg::*;
#(
    parameter int ID_VAL = 0,
    parameter int ID_WIDTH = 6,
    parameter int IN_DATA_WIDTH = 8,
    parameter int OUT_DATA_WIDTH = 24,
    parameter int WGT_DEPTH = 4,
    parameter int SAT_EN = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_clr,
    input  logic                      i_load_vld,
    input  logic [ID_WIDTH-1:0]       i_load_id,
    input  logic [IN_DATA_WIDTH-1:0]  i_load_data,
    output logic                      o_load_vld,
    output logic [ID_WIDTH-1:0]       o_load_id,
    output logic [IN_DATA_WIDTH-1:0]  o_load_data,
    output logic                      o_wgt_full,
    input  logic                      i_pop_vld,
    output logic                      o_pop_vld,
    input  logic [OUT_DATA_WIDTH-1:0] i_up_data,
    input  logic [IN_DATA_WIDTH-1:0]  i_left_data,
    output logic [IN_DATA_WIDTH-1:0]  o_right_data,
    output logic [OUT_DATA_WIDTH-1:0] o_down_data
);
    logic hit;
    logic [IN_DATA_WIDTH-1:0] wgt;
    logic s1_vld, s2_vld;
    logic signed [IN_DATA_WIDTH-1:0] s1_left, s1_wgt;
    logic signed [OUT_DATA_WIDTH-1:0] s1_up;
    logic [OUT_DATA_WIDTH-1:0] s2_sum, sum_nxt;
    logic signed [2*IN_DATA_WIDTH-1:0] prod;
    logic signed [OUT_DATA_WIDTH:0] sum;
    assign hit = i_load_vld && i_load_id == ID_WIDTH'(ID_VAL);
    pe_wgt_bank #(.DEPTH(WGT_DEPTH), .W(IN_DATA_WIDTH)) u_bank (
        .clk(clk),
        .rst_n(rst_n),
        .clr(i_clr),
        .wr_en(hit),
        .wr_data(i_load_data),
        .rd_en(i_pop_vld),
        .rd_data(wgt),
        .full(o_wgt_full)
    );
    // One guard bit above the partial-sum width holds the exact sum before clamping
    always_comb begin
        prod = s1_left * s1_wgt;
        sum = (OUT_DATA_WIDTH + 1)'(prod) + (OUT_DATA_WIDTH + 1)'(s1_up);
        sum_nxt = SAT_EN != 0 ? OUT_DATA_WIDTH'(pe_sat(64'(sum), OUT_DATA_WIDTH)) : sum[OUT_DATA_WIDTH-1:0];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_load_vld <= 1'b0;
            o_load_id <= '0;
            o_load_data <= '0;
            o_right_data <= '0;
            s1_vld <= 1'b0;
            s1_left <= '0;
            s1_wgt <= '0;
            s1_up <= '0;
            s2_vld <= 1'b0;
            s2_sum <= '0;
            o_pop_vld <= 1'b0;
            o_down_data <= '0;
        end else begin
            o_load_vld <= i_load_vld && !hit;
            o_load_id <= i_load_id;
            o_load_data <= i_load_data;
            o_right_data <= i_left_data;
            s1_vld <= i_pop_vld;
            s1_left <= i_left_data;
            s1_wgt <= wgt;
            s1_up <= i_up_data;
            s2_vld <= s1_vld;
            s2_sum <= sum_nxt;
            o_pop_vld <= s2_vld;
            o_down_data <= s2_sum;
        end
    end
endmodule
